// File: rtl/serial_add_scheduler_if.sv
// Request/response handshake bundle for serial_add_scheduler.
// master = the two requesters plus the result consumer, slave = the scheduler.
interface serial_add_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH:0]   rsp_sum;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/serial_add_scheduler.sv
// Round-robin two-port sequencer for a bit-serial adder: accepts an operand pair,
// strobes the external datapath for WIDTH bit cycles and returns the tagged sum.
module serial_add_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_add_scheduler_if.slave bus,
  output logic                  busy,
  output logic                  dp_load,
  output logic                  dp_carry_clr,
  output logic                  dp_shift_en,
  output logic [WIDTH-1:0]      dp_a,
  output logic [WIDTH-1:0]      dp_b,
  input  logic [WIDTH:0]        dp_sum
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] SHIFT   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic grant0, grant1;
  logic accept0, accept1;
  logic idle;

  assign idle = (state_q == IDLE);

  // On a tie the port that did not win last time is granted; the two grants are exclusive.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

  assign accept0 = ~reset & idle & grant0;
  assign accept1 = ~reset & idle & grant1;

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;

  assign busy         = ~idle;
  assign dp_load      = (state_q == LOAD);
  assign dp_carry_clr = (state_q == LOAD);
  assign dp_shift_en  = (state_q == SHIFT);
  assign dp_a         = a_q;
  assign dp_b         = b_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    sum_d        = sum_q;

    case (state_q)
      IDLE: begin
        if (accept0) begin
          a_d          = bus.req0_a;
          b_d          = bus.req0_b;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = LOAD;
        end else if (accept1) begin
          a_d          = bus.req1_a;
          b_d          = bus.req1_b;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // The last shift has landed in the datapath sum register by now.
        sum_d   = dp_sum;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      sum_q        <= sum_d;
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Self-checking bench for serial_add_scheduler: a bit-serial datapath stand-in,
// a transaction-level reference model checked every cycle, and directed vectors.
module tb_serial_add_scheduler;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         busy;
  logic         dp_load;
  logic         dp_carry_clr;
  logic         dp_shift_en;
  logic [W-1:0] dp_a;
  logic [W-1:0] dp_b;
  logic [W:0]   dp_sum;

  serial_add_scheduler_if #(.WIDTH(W)) bus ();

  serial_add_scheduler #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .dp_load      (dp_load),
    .dp_carry_clr (dp_carry_clr),
    .dp_shift_en  (dp_shift_en),
    .dp_a         (dp_a),
    .dp_b         (dp_b),
    .dp_sum       (dp_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial datapath stand-in: operand shift registers, full adder, carry flop, sum shifter.
  logic [W-1:0] sh_a, sh_b, sh_s;
  logic         sh_c;
  logic         fa_s;
  assign fa_s   = sh_a[0] ^ sh_b[0] ^ sh_c;
  assign dp_sum = {sh_c, sh_s};

  always @(posedge clk) begin
    if (dp_load) begin
      sh_a <= dp_a;
      sh_b <= dp_b;
    end
    if (dp_carry_clr) begin
      sh_c <= 1'b0;
      sh_s <= '0;
    end
    if (dp_shift_en) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      sh_c <= (sh_a[0] & sh_b[0]) | (sh_c & (sh_a[0] ^ sh_b[0]));
      sh_s <= {fa_s, sh_s[W-1:1]};
    end
  end

  // Transaction-level reference model and logs of observed handshakes.
  bit           inflight = 0;
  int           age      = 0;
  bit           m_last   = 1;
  bit           m_id     = 0;
  bit           m_rv     = 0;
  logic [W-1:0] m_a      = '0;
  logic [W-1:0] m_b      = '0;
  int           shift_cnt = 0;
  bit           e_load, e_shift, e_rv, e_r0, e_r1;
  logic [W:0]   e_sum;

  int         acc_n = 0;
  int         rsp_n = 0;
  bit         acc_id   [64];
  int         acc_cyc  [64];
  bit         rsp_id_l [64];
  logic [W:0] rsp_sum_l[64];
  logic [W:0] rsp_mod_l[64];
  int         rsp_cyc  [64];
  int         rsp_shf  [64];

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_req0_ready", 32'(bus.req0_ready), 0);
      checkOutput("rst_req1_ready", 32'(bus.req1_ready), 0);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      checkOutput("rst_rsp_sum", 32'(bus.rsp_sum), 0);
      checkOutput("rst_rsp_id", 32'(bus.rsp_id), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_strobes", 32'({dp_load, dp_carry_clr, dp_shift_en}), 0);
      checkOutput("rst_dp_ab", 32'({dp_a, dp_b}), 0);
      inflight  = 0;
      age       = 0;
      m_last    = 1;
      m_id      = 0;
      m_rv      = 0;
      m_a       = '0;
      m_b       = '0;
      shift_cnt = 0;
    end else begin
      if (inflight) age++;
      e_load  = inflight && age == 1;
      e_shift = inflight && age >= 2 && age <= W + 1;
      e_rv    = inflight && age >= W + 3;
      e_r0    = !inflight && bus.req0_valid && (!bus.req1_valid || m_last);
      e_r1    = !inflight && bus.req1_valid && (!bus.req0_valid || !m_last);
      e_sum   = {1'b0, m_a} + {1'b0, m_b};

      checkOutput("busy", 32'(busy), 32'(inflight));
      checkOutput("dp_load", 32'(dp_load), 32'(e_load));
      checkOutput("dp_carry_clr", 32'(dp_carry_clr), 32'(e_load));
      checkOutput("dp_shift_en", 32'(dp_shift_en), 32'(e_shift));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      checkOutput("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
      checkOutput("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
      checkOutput("dp_a", 32'(dp_a), 32'(m_a));
      checkOutput("dp_b", 32'(dp_b), 32'(m_b));
      if (e_rv) begin
        checkOutput("rsp_sum", 32'(bus.rsp_sum), 32'(e_sum));
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      end

      if (inflight && dp_shift_en) shift_cnt++;
      m_rv = e_rv;

      if (e_rv && bus.rsp_ready) begin
        if (rsp_n < 64) begin
          rsp_id_l[rsp_n]  = bus.rsp_id;
          rsp_sum_l[rsp_n] = bus.rsp_sum;
          rsp_mod_l[rsp_n] = e_sum;
          rsp_cyc[rsp_n]   = cyc;
          rsp_shf[rsp_n]   = shift_cnt;
        end
        rsp_n++;
        inflight = 0;
      end

      if (e_r0 || e_r1) begin
        inflight  = 1;
        age       = 0;
        shift_cnt = 0;
        m_id      = e_r1;
        m_last    = e_r1;
        m_a       = e_r1 ? bus.req1_a : bus.req0_a;
        m_b       = e_r1 ? bus.req1_b : bus.req0_b;
        if (acc_n < 64) begin
          acc_id[acc_n]  = e_r1;
          acc_cyc[acc_n] = cyc;
        end
        acc_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAccept(input int target);
    int i = 0;
    while (acc_n < target && i < 100) begin
      tick();
      i++;
    end
    if (acc_n < target) checkOutput("accept_timeout", 32'(acc_n), 32'(target));
  endtask

  task automatic waitResponse(input int target);
    int i = 0;
    while (rsp_n < target && i < 200) begin
      tick();
      i++;
    end
    if (rsp_n < target) checkOutput("rsp_timeout", 32'(rsp_n), 32'(target));
  endtask

  task automatic applyStimulus(input int port, input logic [W-1:0] a, input logic [W-1:0] b);
    int target = acc_n + 1;
    if (port == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
    waitAccept(target);
    if (port == 0) bus.req0_valid = 1'b0;
    else           bus.req1_valid = 1'b0;
  endtask

  task automatic checkResponse(input int idx, input bit id, input logic [W:0] sum);
    if (idx >= rsp_n || idx >= 64) begin
      checkOutput("lit_rsp_missing", 32'(rsp_n), 32'(idx + 1));
    end else begin
      checkOutput("lit_rsp_sum", 32'(rsp_sum_l[idx]), 32'(sum));
      checkOutput("lit_model_sum", 32'(rsp_mod_l[idx]), 32'(sum));
      checkOutput("lit_rsp_id", 32'(rsp_id_l[idx]), 32'(id));
    end
  endtask

  task automatic runOne(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] sum);
    int idx = rsp_n;
    applyStimulus(port, a, b);
    waitResponse(idx + 1);
    checkResponse(idx, port[0], sum);
  endtask

  initial begin
    int base_acc;
    int base_rsp;

    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;
    repeat (2) tick();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    checkOutput("lit_rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Single request: latency and number of shift pulses.
    runOne(0, 8'h3C, 8'h5A, 9'h096);
    if (rsp_n >= 1 && acc_n >= 1) begin
      checkOutput("lit_latency", 32'(rsp_cyc[0] - acc_cyc[0]), 11);
      checkOutput("lit_shift_pulses", 32'(rsp_shf[0]), 8);
    end else begin
      checkOutput("lit_first_txn", 32'(rsp_n), 1);
    end

    // Carry-out boundaries.
    runOne(0, 8'hFF, 8'h01, 9'h100);
    runOne(1, 8'hFF, 8'hFF, 9'h1FE);
    runOne(0, 8'h00, 8'h00, 9'h000);

    // Backpressure: result held for 20 cycles while another request waits.
    bus.rsp_ready = 1'b0;
    base_rsp = rsp_n;
    applyStimulus(0, 8'h80, 8'h80);
    for (int i = 0; i < 50 && !m_rv; i++) tick();
    checkOutput("lit_bp_rsp_valid_seen", 32'(m_rv), 1);
    base_acc = acc_n;
    bus.req1_a = 8'h01; bus.req1_b = 8'h02; bus.req1_valid = 1'b1;
    repeat (20) tick();
    checkOutput("lit_bp_no_transfer", 32'(rsp_n), 32'(base_rsp));
    checkOutput("lit_bp_valid", 32'(bus.rsp_valid), 1);
    checkOutput("lit_bp_sum", 32'(bus.rsp_sum), 32'h100);
    checkOutput("lit_bp_id", 32'(bus.rsp_id), 0);
    checkOutput("lit_bp_req1_ready", 32'(bus.req1_ready), 0);
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("lit_bp_one_transfer", 32'(rsp_n), 32'(base_rsp + 1));
    waitAccept(base_acc + 1);
    bus.req1_valid = 1'b0;
    waitResponse(base_rsp + 2);
    checkResponse(base_rsp, 1'b0, 9'h100);
    checkResponse(base_rsp + 1, 1'b1, 9'h003);

    // Operand stability: requester data changes after acceptance.
    base_rsp = rsp_n;
    applyStimulus(0, 8'h55, 8'hAA);
    bus.req0_a = 8'hFF;
    bus.req0_b = 8'hFF;
    repeat (3) tick();
    checkOutput("lit_hold_dp_a", 32'(dp_a), 32'h55);
    checkOutput("lit_hold_dp_b", 32'(dp_b), 32'hAA);
    waitResponse(base_rsp + 1);
    checkResponse(base_rsp, 1'b0, 9'h0FF);

    // Reset in the middle of SHIFT aborts the transaction.
    applyStimulus(1, 8'h0F, 8'h0F);
    repeat (3) tick();
    checkOutput("lit_midshift_shift", 32'(dp_shift_en), 1);
    reset = 1'b1;
    #1;
    checkOutput("lit_abort_busy", 32'(busy), 0);
    checkOutput("lit_abort_shift", 32'(dp_shift_en), 0);
    checkOutput("lit_abort_dp_a", 32'(dp_a), 0);
    repeat (2) tick();
    reset = 1'b0;
    base_rsp = rsp_n;
    repeat (20) tick();
    checkOutput("lit_abort_no_rsp", 32'(rsp_n), 32'(base_rsp));

    // Contention: both ports valid, grants alternate starting with port 0.
    base_acc = acc_n;
    base_rsp = rsp_n;
    bus.req0_a = 8'h12; bus.req0_b = 8'h34; bus.req0_valid = 1'b1;
    bus.req1_a = 8'hA5; bus.req1_b = 8'h7B; bus.req1_valid = 1'b1;
    waitAccept(base_acc + 4);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    waitResponse(base_rsp + 4);
    for (int k = 0; k < 4; k++) begin
      if (base_acc + k < acc_n && base_acc + k < 64) begin
        checkOutput("lit_rr_grant", 32'(acc_id[base_acc + k]), 32'(k % 2));
        if (k > 0)
          checkOutput("lit_rr_spacing", 32'(acc_cyc[base_acc + k] - acc_cyc[base_acc + k - 1]), 12);
      end else begin
        checkOutput("lit_rr_missing", 32'(acc_n), 32'(base_acc + k + 1));
      end
      checkResponse(base_rsp + k, k[0], k[0] ? 9'h120 : 9'h046);
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, tests run %0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_add_scheduler.md
# serial_add_scheduler

Sequencer and two-port arbiter for the bit-serial adder datapath (two operand shift registers, full adder, carry flip-flop, sum shift register). It accepts add requests from two independent requesters over valid/ready handshakes and grants them round-robin. It drives the datapath's load, shift-enable and carry-clear strobes for exactly WIDTH bit cycles, captures the WIDTH+1-bit sum, and returns it tagged with the requester ID over a valid/ready response channel.

## Interface
- WIDTH, 8, operand width in bits (≥2); the sum is WIDTH+1 bits
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req0_valid / req1_valid  in  1  requester n has an operand pair
- req0_ready / req1_ready  out  1  request n accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands of requester n
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester the result belongs to
- rsp_sum  out  WIDTH+1  A+B, carry-out in MSB
- busy  out  1  high in every state except IDLE
- dp_load  out  1  load operand shift registers from dp_a/dp_b
- dp_carry_clr  out  1  clear carry flip-flop and sum register
- dp_shift_en  out  1  advance datapath one bit (LSB first)
- dp_a, dp_b  out  WIDTH  registered operands presented to datapath
- dp_sum  in  WIDTH+1  parallel sum from datapath sum register

## Operation
- States: IDLE → LOAD → SHIFT → CAPTURE → RESP → IDLE.
- IDLE: ready is combinational. reqN_ready = (state==IDLE) & reqN_valid & grant(N). At most one ready is high per cycle. On acceptance, register the operands into dp_a/dp_b, register the ID, toggle last_grant to N, and go to LOAD.
- Arbitration: if only one valid is high, that port wins. If both are high, the port ≠ last_grant wins. last_grant resets to 1, so port 0 wins the first tie.
- LOAD (1 cycle): dp_load=1, dp_carry_clr=1. The bit counter is cleared to 0.
- SHIFT (WIDTH cycles): dp_shift_en=1 and the counter increments each cycle. Leave SHIFT when counter==WIDTH-1.
- CAPTURE (1 cycle): strobes are low. Latch dp_sum into rsp_sum.
- RESP: rsp_valid=1, with rsp_sum and rsp_id held stable. When rsp_valid & rsp_ready, go to IDLE next cycle. A new request is accepted no earlier than the cycle after that.
- dp_a/dp_b hold their value until the next acceptance. They are never modified during a transaction.
- Requests arriving while busy wait. Requesters must hold valid and data stable until ready.
- Strobes are mutually exclusive. All are low in IDLE, CAPTURE and RESP.

## Timing
- Reset (async assert, sync deassert assumed by the system):
  - state=IDLE, counter=0, last_grant=1.
  - rsp_valid=0, rsp_sum=0, rsp_id=0.
  - dp_a=dp_b=0, all strobes=0, busy=0.
  - Both ready outputs are 0 while reset is high.
- Acceptance at edge T means the handshake is seen in cycle T:
  - LOAD in cycle T+1.
  - SHIFT in cycles T+2 … T+WIDTH+1.
  - CAPTURE in cycle T+WIDTH+2.
  - rsp_valid first high in cycle T+WIDTH+3. For WIDTH=8 this is T+11.
- Minimum spacing between accepts is WIDTH+4 cycles, reached when rsp_ready is tied high.
- rsp_ready low stalls in RESP indefinitely with no output change.
- Reset mid-transaction aborts immediately. The in-flight result is discarded, no response is issued, and last_grant returns to 1.
- A req_valid dropping before acceptance is legal and simply not granted. A req_valid dropping after acceptance has no effect.
- Overflow: carry-out appears in rsp_sum[WIDTH]. No wrap or saturation.

## Test plan
- Reset values: assert reset mid-SHIFT → all outputs return to reset values in the same cycle, and no rsp_valid follows deassert.
- Single request, WIDTH=8: port 0 sends A=8'h3C, B=8'h5A with rsp_ready=1 → dp_load at T+1, 8 dp_shift_en pulses, and rsp_valid at T+11 with rsp_sum=9'h096, rsp_id=0.
- Carry-out boundary: A=8'hFF, B=8'h01 → rsp_sum=9'h100. A=8'hFF, B=8'hFF → 9'h1FE. A=0, B=0 → 9'h000.
- Contention: both ports valid continuously with distinct operands → grants alternate 0,1,0,1. Each rsp_id matches its operands, and consecutive accepts are exactly 12 cycles apart.
- Backpressure: rsp_ready held low for 20 cycles → rsp_valid, rsp_sum and rsp_id stay stable, req ready stays low, and a single transfer occurs when rsp_ready rises.
- Operand stability: change req0_a/req0_b while busy → dp_a/dp_b unchanged, and the result reflects the operands registered at acceptance.
